// File: rtl/usb_xfer_ctrl.sv
// USB full-speed device transaction controller.
// Decodes OUT/IN/SETUP tokens addressed to this device, forwards OUT/SETUP data bytes,
// tracks per-endpoint DATA0/DATA1 toggles, and schedules the handshake or IN data packet
// on the transmitter.
// Optional feature: define USB_STALL_EN to add the ep_stall input and STALL responses.
module usb_xfer_ctrl #(
    parameter int unsigned TIMEOUT = 120
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  rx_packet_pid,
    input  logic [10:0] rx_packet_addr,
    input  logic [7:0]  rx_packet_byte,
    input  logic        rx_packet_byte_en,
    input  logic        rx_packet_valid,
    input  logic        rx_packet_fin,
    input  logic [6:0]  dev_addr,
    input  logic [3:0]  ep_out_ready,
    input  logic [3:0]  ep_in_valid,
`ifdef USB_STALL_EN
    input  logic [3:0]  ep_stall,
`endif
    input  logic        tx_busy,
    input  logic        tx_done,
    output logic        tx_start,
    output logic [3:0]  tx_pid,
    output logic [1:0]  cur_ep,
    output logic [7:0]  out_byte,
    output logic        out_byte_en,
    output logic        out_setup,
    output logic        out_commit,
    output logic        out_discard,
    output logic        in_ack,
    output logic        rx_timeout
);

    localparam logic [3:0] PidOut   = 4'b0001;
    localparam logic [3:0] PidIn    = 4'b1001;
    localparam logic [3:0] PidSetup = 4'b1101;
    localparam logic [3:0] PidData0 = 4'b0011;
    localparam logic [3:0] PidData1 = 4'b1011;
    localparam logic [3:0] PidAck   = 4'b0010;
    localparam logic [3:0] PidNak   = 4'b1010;
    localparam logic [3:0] PidStall = 4'b1110;

    localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWaitData,
        StDataRx,
        StSendHs,
        StSendData,
        StWaitAck
    } state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [3:0]      toggle_q;
    logic            started_q;
    logic            pend_commit_q;
    logic            pend_discard_q;

    logic            tx_start_q;
    logic [3:0]      tx_pid_q;
    logic [1:0]      cur_ep_q;
    logic [7:0]      out_byte_q;
    logic            out_byte_en_q;
    logic            out_setup_q;
    logic            out_commit_q;
    logic            out_discard_q;
    logic            in_ack_q;
    logic            rx_timeout_q;

    logic [1:0]      tok_ep;
    logic            tok_hit;
    logic            is_token;
    logic            is_data;
    logic            data_tog;
    logic            stall_in;
    logic            stall_out;

    assign tok_ep   = rx_packet_addr[8:7];
    // Endpoint field must be 0..3, so its upper two bits have to be zero.
    assign tok_hit  = rx_packet_fin && rx_packet_valid && (rx_packet_addr[6:0] == dev_addr)
                      && (rx_packet_addr[10:9] == 2'b00);
    assign is_token = (rx_packet_pid == PidOut) || (rx_packet_pid == PidIn)
                      || (rx_packet_pid == PidSetup);
    assign is_data  = (rx_packet_pid == PidData0) || (rx_packet_pid == PidData1);
    assign data_tog = rx_packet_pid[3];

`ifdef USB_STALL_EN
    assign stall_in  = ep_stall[tok_ep];
    // A SETUP transaction overrides the stall for its data stage.
    assign stall_out = ep_stall[cur_ep_q] && !out_setup_q;
`else
    assign stall_in  = 1'b0;
    assign stall_out = 1'b0;
`endif

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            toggle_q       <= '0;
            started_q      <= 1'b0;
            pend_commit_q  <= 1'b0;
            pend_discard_q <= 1'b0;
            tx_start_q     <= 1'b0;
            tx_pid_q       <= 4'b0000;
            cur_ep_q       <= 2'd0;
            out_byte_q     <= 8'h00;
            out_byte_en_q  <= 1'b0;
            out_setup_q    <= 1'b0;
            out_commit_q   <= 1'b0;
            out_discard_q  <= 1'b0;
            in_ack_q       <= 1'b0;
            rx_timeout_q   <= 1'b0;
        end else begin
            tx_start_q     <= 1'b0;
            in_ack_q       <= 1'b0;
            rx_timeout_q   <= 1'b0;
            out_byte_en_q  <= 1'b0;
            // Data verdicts are delayed one cycle so a byte arriving with fin is
            // forwarded before the commit/discard pulse.
            out_commit_q   <= pend_commit_q;
            out_discard_q  <= pend_discard_q;
            pend_commit_q  <= 1'b0;
            pend_discard_q <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (tok_hit && is_token) begin
                        cur_ep_q <= tok_ep;
                        cnt_q    <= '0;
                        if (rx_packet_pid == PidSetup) begin
                            toggle_q[tok_ep] <= 1'b0;
                            out_setup_q      <= 1'b1;
                            state_q          <= StWaitData;
                        end else if (rx_packet_pid == PidOut) begin
                            out_setup_q <= 1'b0;
                            state_q     <= StWaitData;
                        end else if (stall_in) begin
                            tx_pid_q <= PidStall;
                            state_q  <= StSendHs;
                        end else if (ep_in_valid[tok_ep]) begin
                            tx_pid_q <= toggle_q[tok_ep] ? PidData1 : PidData0;
                            state_q  <= StSendData;
                        end else begin
                            tx_pid_q <= PidNak;
                            state_q  <= StSendHs;
                        end
                    end
                end

                StWaitData, StDataRx: begin
                    out_byte_q    <= rx_packet_byte;
                    out_byte_en_q <= rx_packet_byte_en;
                    if (rx_packet_fin) begin
                        if (!rx_packet_valid || !is_data) begin
                            pend_discard_q <= 1'b1;
                            state_q        <= StIdle;
                        end else if (stall_out) begin
                            pend_discard_q <= 1'b1;
                            tx_pid_q       <= PidStall;
                            state_q        <= StSendHs;
                        end else if (data_tog != toggle_q[cur_ep_q]) begin
                            // Host missed our ACK and resent: drop data, ACK again.
                            pend_discard_q <= 1'b1;
                            tx_pid_q       <= PidAck;
                            state_q        <= StSendHs;
                        end else if (out_setup_q || ep_out_ready[cur_ep_q]) begin
                            pend_commit_q      <= 1'b1;
                            toggle_q[cur_ep_q] <= ~toggle_q[cur_ep_q];
                            tx_pid_q           <= PidAck;
                            state_q            <= StSendHs;
                        end else begin
                            pend_discard_q <= 1'b1;
                            tx_pid_q       <= PidNak;
                            state_q        <= StSendHs;
                        end
                    end else if (state_q == StWaitData) begin
                        if (rx_packet_byte_en) begin
                            state_q <= StDataRx;
                        end else if (cnt_q == CntLast) begin
                            rx_timeout_q  <= 1'b1;
                            out_discard_q <= 1'b1;
                            state_q       <= StIdle;
                        end else begin
                            cnt_q <= cnt_q + CntW'(1);
                        end
                    end
                end

                StSendHs, StSendData: begin
                    if (!started_q) begin
                        if (!tx_busy) begin
                            tx_start_q <= 1'b1;
                            started_q  <= 1'b1;
                        end
                    end else if (tx_done) begin
                        started_q <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= (state_q == StSendHs) ? StIdle : StWaitAck;
                    end
                end

                StWaitAck: begin
                    if (rx_packet_fin) begin
                        if (rx_packet_valid && (rx_packet_pid == PidAck)) begin
                            in_ack_q           <= 1'b1;
                            toggle_q[cur_ep_q] <= ~toggle_q[cur_ep_q];
                        end
                        state_q <= StIdle;
                    end else if (cnt_q == CntLast) begin
                        rx_timeout_q <= 1'b1;
                        state_q      <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

    assign tx_start    = tx_start_q;
    assign tx_pid      = tx_pid_q;
    assign cur_ep      = cur_ep_q;
    assign out_byte    = out_byte_q;
    assign out_byte_en = out_byte_en_q;
    assign out_setup   = out_setup_q;
    assign out_commit  = out_commit_q;
    assign out_discard = out_discard_q;
    assign in_ack      = in_ack_q;
    assign rx_timeout  = rx_timeout_q;

endmodule

// File: tb/tb_usb_xfer_ctrl.sv
// Scoreboard bench for usb_xfer_ctrl: stimulus pushes expected output events,
// a negedge monitor pops and compares every pulse the DUT produces.
module tb_usb_xfer_ctrl;

    localparam logic [3:0] PidOut   = 4'b0001;
    localparam logic [3:0] PidIn    = 4'b1001;
    localparam logic [3:0] PidSetup = 4'b1101;
    localparam logic [3:0] PidData0 = 4'b0011;
    localparam logic [3:0] PidData1 = 4'b1011;
    localparam logic [3:0] PidAck   = 4'b0010;
    localparam logic [3:0] PidNak   = 4'b1010;

    localparam logic [2:0] EvByte    = 3'd0;
    localparam logic [2:0] EvCommit  = 3'd1;
    localparam logic [2:0] EvDiscard = 3'd2;
    localparam logic [2:0] EvTimeout = 3'd3;
    localparam logic [2:0] EvTx      = 3'd4;
    localparam logic [2:0] EvInAck   = 3'd5;

    typedef struct packed {
        logic [2:0] kind;
        logic [7:0] data;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  rx_packet_pid = '0;
    logic [10:0] rx_packet_addr = '0;
    logic [7:0]  rx_packet_byte = '0;
    logic        rx_packet_byte_en = 1'b0;
    logic        rx_packet_valid = 1'b0;
    logic        rx_packet_fin = 1'b0;
    logic [6:0]  dev_addr = 7'h05;
    logic [3:0]  ep_out_ready = '0;
    logic [3:0]  ep_in_valid = '0;
`ifdef USB_STALL_EN
    logic [3:0]  ep_stall = '0;
`endif
    logic        tx_busy = 1'b0;
    logic        tx_done = 1'b0;
    logic        tx_start;
    logic [3:0]  tx_pid;
    logic [1:0]  cur_ep;
    logic [7:0]  out_byte;
    logic        out_byte_en;
    logic        out_setup;
    logic        out_commit;
    logic        out_discard;
    logic        in_ack;
    logic        rx_timeout;

    int  total = 0;
    int  bad = 0;
    ev_t exp_q[$];

    usb_xfer_ctrl #(.TIMEOUT(120)) dut (
        .clk               (clk),
        .rst               (rst),
        .rx_packet_pid     (rx_packet_pid),
        .rx_packet_addr    (rx_packet_addr),
        .rx_packet_byte    (rx_packet_byte),
        .rx_packet_byte_en (rx_packet_byte_en),
        .rx_packet_valid   (rx_packet_valid),
        .rx_packet_fin     (rx_packet_fin),
        .dev_addr          (dev_addr),
        .ep_out_ready      (ep_out_ready),
        .ep_in_valid       (ep_in_valid),
`ifdef USB_STALL_EN
        .ep_stall          (ep_stall),
`endif
        .tx_busy           (tx_busy),
        .tx_done           (tx_done),
        .tx_start          (tx_start),
        .tx_pid            (tx_pid),
        .cur_ep            (cur_ep),
        .out_byte          (out_byte),
        .out_byte_en       (out_byte_en),
        .out_setup         (out_setup),
        .out_commit        (out_commit),
        .out_discard       (out_discard),
        .in_ack            (in_ack),
        .rx_timeout        (rx_timeout)
    );

    always #5 clk = ~clk;

    task automatic expect_ev(input logic [2:0] kind, input logic [7:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic observe(input logic [2:0] kind, input logic [7:0] data);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: got kind=%0d data=%h, want none", kind, data);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.data != data) begin
                bad++;
                $display("FAIL event: got kind=%0d data=%h, want kind=%0d data=%h",
                         kind, data, e.kind, e.data);
            end
        end
    endtask

    // Monitor: every output pulse is matched against the scoreboard queue.
    initial begin
        forever begin
            @(negedge clk);
            if (out_byte_en) observe(EvByte, out_byte);
            if (out_commit)  observe(EvCommit, 8'h00);
            if (out_discard) observe(EvDiscard, 8'h00);
            if (rx_timeout)  observe(EvTimeout, 8'h00);
            if (tx_start)    observe(EvTx, {4'h0, tx_pid});
            if (in_ack)      observe(EvInAck, 8'h00);
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_token(input logic [3:0] pid, input logic [6:0] a, input logic [3:0] ep);
        rx_packet_pid   = pid;
        rx_packet_addr  = {ep, a};
        rx_packet_valid = 1'b1;
        rx_packet_fin   = 1'b1;
        tick();
        rx_packet_fin   = 1'b0;
        rx_packet_valid = 1'b0;
    endtask

    // Sends n bytes base, base+1, ...; fin either with the last byte or a cycle later.
    task automatic send_data(input logic [3:0] pid, input int n, input logic [7:0] base,
                             input logic valid, input logic fin_with_last);
        for (int i = 0; i < n; i++) expect_ev(EvByte, base + 8'(i));
        rx_packet_pid = pid;
        for (int i = 0; i < n; i++) begin
            rx_packet_byte    = base + 8'(i);
            rx_packet_byte_en = 1'b1;
            if (i == n - 1 && fin_with_last) begin
                rx_packet_valid = valid;
                rx_packet_fin   = 1'b1;
            end
            tick();
        end
        rx_packet_byte_en = 1'b0;
        if (!fin_with_last) begin
            rx_packet_valid = valid;
            rx_packet_fin   = 1'b1;
            tick();
        end
        rx_packet_fin   = 1'b0;
        rx_packet_valid = 1'b0;
    endtask

    // Waits (bounded) for tx_start, then lets the transmitter finish.
    task automatic finish_tx();
        bit seen = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (tx_start) begin
                seen = 1'b1;
                break;
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL tx_start_wait: got no tx_start in 60 cycles, want one");
        end
        tick();
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic count_timeout(input string name);
        int n = 0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (rx_timeout) break;
        end
        chk(name, 8'(n), 8'd120);
        #1;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 40; k++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s: got %0d events outstanding, want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_tx_start"}, 8'(tx_start), 8'h00);
        chk({tag, "_tx_pid"}, 8'(tx_pid), 8'h00);
        chk({tag, "_cur_ep"}, 8'(cur_ep), 8'h00);
        chk({tag, "_out_byte"}, out_byte, 8'h00);
        chk({tag, "_out_byte_en"}, 8'(out_byte_en), 8'h00);
        chk({tag, "_out_setup"}, 8'(out_setup), 8'h00);
        chk({tag, "_out_commit"}, 8'(out_commit), 8'h00);
        chk({tag, "_out_discard"}, 8'(out_discard), 8'h00);
        chk({tag, "_in_ack"}, 8'(in_ack), 8'h00);
        chk({tag, "_rx_timeout"}, 8'(rx_timeout), 8'h00);
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        check_zero("reset");

        // OUT ep1, DATA0 x3, buffer ready; transmitter busy delays the ACK.
        ep_out_ready = 4'b0010;
        tx_busy = 1'b1;
        send_token(PidOut, 7'h05, 4'd1);
        chk("out_cur_ep", 8'(cur_ep), 8'd1);
        chk("out_setup_clr", 8'(out_setup), 8'd0);
        send_data(PidData0, 3, 8'hA1, 1'b1, 1'b0);
        expect_ev(EvCommit, 8'h00);
        expect_ev(EvTx, {4'h0, PidAck});
        repeat (4) tick();
        tx_busy = 1'b0;
        finish_tx();
        drain("out_commit");

        // Duplicate DATA0 (last byte with fin): discard, ACK, toggle stays 1.
        send_token(PidOut, 7'h05, 4'd1);
        send_data(PidData0, 3, 8'hB0, 1'b1, 1'b1);
        expect_ev(EvDiscard, 8'h00);
        expect_ev(EvTx, {4'h0, PidAck});
        finish_tx();
        drain("out_dup");

        // DATA1 now matches toggle 1: commit.
        send_token(PidOut, 7'h05, 4'd1);
        send_data(PidData1, 1, 8'hC0, 1'b1, 1'b0);
        expect_ev(EvCommit, 8'h00);
        expect_ev(EvTx, {4'h0, PidAck});
        finish_tx();
        drain("out_data1");

        // No buffer space: NAK.
        ep_out_ready = 4'b0000;
        send_token(PidOut, 7'h05, 4'd1);
        send_data(PidData0, 2, 8'hD0, 1'b1, 1'b0);
        expect_ev(EvDiscard, 8'h00);
        expect_ev(EvTx, {4'h0, PidNak});
        finish_tx();
        drain("out_nak");

        // IN ep2: NAK when empty, then DATA0, ACK flips toggle.
        expect_ev(EvTx, {4'h0, PidNak});
        send_token(PidIn, 7'h05, 4'd2);
        finish_tx();
        drain("in_nak");
        ep_in_valid = 4'b0100;
        expect_ev(EvTx, {4'h0, PidData0});
        send_token(PidIn, 7'h05, 4'd2);
        chk("in_cur_ep", 8'(cur_ep), 8'd2);
        finish_tx();
        expect_ev(EvInAck, 8'h00);
        send_token(PidAck, 7'h00, 4'd0);
        drain("in_data0_ack");
        // DATA1; a non-ACK reply leaves toggle alone.
        expect_ev(EvTx, {4'h0, PidData1});
        send_token(PidIn, 7'h05, 4'd2);
        finish_tx();
        send_token(PidNak, 7'h00, 4'd0);
        drain("in_no_ack");
        // DATA1 again; no reply at all times out without flipping.
        expect_ev(EvTx, {4'h0, PidData1});
        send_token(PidIn, 7'h05, 4'd2);
        finish_tx();
        expect_ev(EvTimeout, 8'h00);
        count_timeout("ack_timeout_cycles");
        drain("in_ack_timeout");
        expect_ev(EvTx, {4'h0, PidData1});
        send_token(PidIn, 7'h05, 4'd2);
        finish_tx();
        expect_ev(EvInAck, 8'h00);
        send_token(PidAck, 7'h00, 4'd0);
        drain("in_data1_ack");

        // Ignored packets: wrong address, endpoint 5, non-token PID, stray ACK/tx_done.
        send_token(PidOut, 7'h06, 4'd1);
        send_token(PidOut, 7'h05, 4'd5);
        send_token(PidData0, 7'h05, 4'd1);
        send_token(PidAck, 7'h05, 4'd1);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        repeat (5) tick();
        chk("ignored_cur_ep", 8'(cur_ep), 8'd2);
        drain("ignored");

        // OUT with no data: timeout plus discard after 120 cycles.
        expect_ev(EvDiscard, 8'h00);
        expect_ev(EvTimeout, 8'h00);
        send_token(PidOut, 7'h05, 4'd3);
        count_timeout("data_timeout_cycles");
        drain("out_timeout");

        // SETUP ep0: invalid data is discarded silently; valid data never NAKed.
        ep_out_ready = 4'b0000;
        send_token(PidSetup, 7'h05, 4'd0);
        chk("setup_flag", 8'(out_setup), 8'd1);
        chk("setup_cur_ep", 8'(cur_ep), 8'd0);
        send_data(PidData0, 1, 8'hE0, 1'b0, 1'b0);
        expect_ev(EvDiscard, 8'h00);
        repeat (4) tick();
        drain("setup_invalid");
        send_token(PidSetup, 7'h05, 4'd0);
        send_data(PidData0, 2, 8'hE8, 1'b1, 1'b0);
        expect_ev(EvCommit, 8'h00);
        expect_ev(EvTx, {4'h0, PidAck});
        finish_tx();
        drain("setup_commit");
        // After SETUP commit ep0 toggle is 1: DATA1 OUT commits.
        ep_out_ready = 4'b0001;
        send_token(PidOut, 7'h05, 4'd0);
        chk("out_after_setup_flag", 8'(out_setup), 8'd0);
        send_data(PidData1, 1, 8'hF0, 1'b1, 1'b0);
        expect_ev(EvCommit, 8'h00);
        expect_ev(EvTx, {4'h0, PidAck});
        finish_tx();
        drain("setup_toggle");

        // Set ep1 toggle to 1, then reset in the middle of a data packet.
        ep_out_ready = 4'b0010;
        send_token(PidOut, 7'h05, 4'd1);
        send_data(PidData0, 1, 8'h20, 1'b1, 1'b0);
        expect_ev(EvCommit, 8'h00);
        expect_ev(EvTx, {4'h0, PidAck});
        finish_tx();
        drain("pre_reset");
        send_token(PidOut, 7'h05, 4'd1);
        expect_ev(EvByte, 8'h10);
        expect_ev(EvByte, 8'h11);
        rx_packet_pid = PidData1;
        for (int i = 0; i < 3; i++) begin
            rx_packet_byte    = 8'h10 + 8'(i);
            rx_packet_byte_en = 1'b1;
            if (i == 2) rst = 1'b1;
            tick();
        end
        rst = 1'b0;
        rx_packet_byte_en = 1'b0;
        check_zero("mid_reset");
        rx_packet_valid = 1'b1;
        rx_packet_fin   = 1'b1;
        tick();
        rx_packet_fin   = 1'b0;
        rx_packet_valid = 1'b0;
        repeat (4) tick();
        drain("mid_reset");
        // Toggles were cleared: DATA0 on ep1 commits again.
        send_token(PidOut, 7'h05, 4'd1);
        send_data(PidData0, 1, 8'h30, 1'b1, 1'b0);
        expect_ev(EvCommit, 8'h00);
        expect_ev(EvTx, {4'h0, PidAck});
        finish_tx();
        drain("post_reset");

`ifdef USB_STALL_EN
        ep_stall = 4'b0001;
        ep_in_valid = 4'b0001;
        expect_ev(EvTx, 8'h0E);
        send_token(PidIn, 7'h05, 4'd0);
        finish_tx();
        drain("stall_in");
        ep_out_ready = 4'b0001;
        send_token(PidOut, 7'h05, 4'd0);
        send_data(PidData0, 1, 8'h40, 1'b1, 1'b0);
        expect_ev(EvDiscard, 8'h00);
        expect_ev(EvTx, 8'h0E);
        finish_tx();
        drain("stall_out");
        send_token(PidSetup, 7'h05, 4'd0);
        send_data(PidData0, 1, 8'h50, 1'b1, 1'b0);
        expect_ev(EvCommit, 8'h00);
        expect_ev(EvTx, {4'h0, PidAck});
        finish_tx();
        drain("stall_setup");
        ep_stall = 4'b0000;
`endif

        repeat (5) tick();
        drain("final");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
